// File: rtl/arbiter_rr_pkt_n.sv
// ---------------------------------------------------------------------------
// arbiter_rr_pkt_n
//
// N-to-1 round-robin arbiter for valid/ready packet streams. A requester that
// wins arbitration keeps the grant from its first accepted beat through its
// last beat, so packets from different sources are never interleaved. The
// output side is a single registered pipeline stage that still moves one beat
// per cycle when the consumer is always ready.
//
// Parameters:
//   DWIDTH  payload width in bits
//   N       number of requesters (N >= 2)
//   SWIDTH  width of the source index, derived from N (leave at default)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   per-requester valid          (unpacked [N-1:0])
//   in_data    per-requester payload        (unpacked [N-1:0])
//   in_last    per-requester last-beat flag (unpacked [N-1:0])
//   in_ready   per-requester ready          (unpacked [N-1:0])
//   out_valid  registered output valid
//   out_data   registered output payload
//   out_last   registered output last flag
//   out_src    index of the requester that supplied the current output beat
//   out_ready  downstream ready
// ---------------------------------------------------------------------------
module arbiter_rr_pkt_n #(
  parameter int DWIDTH = 20,
  parameter int N      = 2,
  parameter int SWIDTH = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid [N-1:0],
  input  logic [DWIDTH-1:0] in_data  [N-1:0],
  input  logic              in_last  [N-1:0],
  output logic              in_ready [N-1:0],
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic [SWIDTH-1:0] out_src,
  input  logic              out_ready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SWIDTH-1:0] owner_q, owner_d;
  logic [SWIDTH-1:0] ptr_q, ptr_d;

  logic              outValid_q;
  logic [DWIDTH-1:0] outData_q;
  logic              outLast_q;
  logic [SWIDTH-1:0] outSrc_q;

  logic              load;
  logic              scanFound;
  logic [SWIDTH-1:0] scanIdx;
  logic [SWIDTH-1:0] sel;
  logic              selActive;
  logic              grantReady;
  logic              accept;
  logic              selLast;

  // Advance an index by one, wrapping from N-1 back to 0 (N need not be a
  // power of two, so plain overflow is not enough).
  function automatic logic [SWIDTH-1:0] wrapInc(input logic [SWIDTH-1:0] x);
    if (x == SWIDTH'(N - 1)) begin
      return '0;
    end
    return x + SWIDTH'(1);
  endfunction

  // The output stage can take a new beat when it is empty or its current
  // beat is leaving this cycle.
  assign load = ~outValid_q | out_ready;

  // Round-robin search used while no packet is in flight: walk the
  // requesters starting at ptr and take the first one that is valid.
  always_comb begin
    int                idx;
    logic [SWIDTH-1:0] cand;
    scanFound = 1'b0;
    scanIdx   = ptr_q;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      cand = SWIDTH'(idx);
      if (!scanFound && in_valid[cand]) begin
        scanFound = 1'b1;
        scanIdx   = cand;
      end
    end
  end

  // The selected source is the scan winner when idle and the locked owner
  // otherwise. While locked the owner is offered ready even when it has no
  // valid beat, so a gap in its packet becomes a bubble downstream instead
  // of letting another requester slip in.
  always_comb begin
    sel       = scanIdx;
    selActive = scanFound;
    if (state_q == LOCKED) begin
      sel       = owner_q;
      selActive = 1'b1;
    end
  end

  assign grantReady = selActive & load & ~rst;
  assign accept     = grantReady & in_valid[sel];
  assign selLast    = in_last[sel];

  // Only the selected requester ever sees ready.
  for (genvar i = 0; i < N; i++) begin : gen_ready
    assign in_ready[i] = grantReady & (sel == SWIDTH'(i));
  end

  // Next-state logic for the packet lock and the fairness pointer. The
  // pointer only moves when a packet finishes, so a long packet does not
  // shift priority half way through.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (selLast) begin
            ptr_d = wrapInc(sel);
          end else begin
            state_d = LOCKED;
            owner_d = sel;
          end
        end
      end
      LOCKED: begin
        if (accept && selLast) begin
          state_d = IDLE;
          ptr_d   = wrapInc(owner_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbitration state registers. Reset abandons any packet in progress and
  // hands top priority back to requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output pipeline register. A newly accepted beat overwrites one that is
  // leaving in the same cycle, which is what keeps throughput at one beat
  // per cycle. Payload, last and source only change on an accept, so they
  // stay stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outLast_q  <= 1'b0;
      outSrc_q   <= '0;
    end else if (accept) begin
      outValid_q <= 1'b1;
      outData_q  <= in_data[sel];
      outLast_q  <= selLast;
      outSrc_q   <= sel;
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_last  = outLast_q;
  assign out_src   = outSrc_q;

endmodule

// File: tb/tb_arbiter_rr_pkt_n.sv
// ---------------------------------------------------------------------------
// tb_arbiter_rr_pkt_n
//
// Bench for arbiter_rr_pkt_n with N=3, DWIDTH=20. A table of per-cycle
// records gives the inputs, the expected in_ready pattern, the expected
// out_valid and, when a beat should be accepted, the beat that must later
// appear at the output. Expected beats go into a scoreboard queue and are
// compared when the output transfers. Backpressure and reset in the middle
// of a packet are written out by hand.
// ---------------------------------------------------------------------------
module tb_arbiter_rr_pkt_n;

  localparam int N  = 3;
  localparam int DW = 20;
  localparam int SW = 2;

  logic          clk;
  logic          rst;
  logic          inValid [N-1:0];
  logic [DW-1:0] inData  [N-1:0];
  logic          inLast  [N-1:0];
  logic          inReady [N-1:0];
  logic          outValid;
  logic [DW-1:0] outData;
  logic          outLast;
  logic [SW-1:0] outSrc;
  logic          outReady;

  typedef struct {
    logic [N-1:0]         valid;
    logic [N-1:0]         last;
    logic [N-1:0][DW-1:0] data;
    logic                 outReady;
    logic [N-1:0]         expReady;
    logic                 expOutValid;
    logic                 push;
    logic [DW-1:0]        pData;
    logic                 pLast;
    logic [SW-1:0]        pSrc;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [SW-1:0] src;
  } beat_t;

  vec_t  vecs[$];
  beat_t sbQ[$];
  int    checks = 0;
  int    errors = 0;

  arbiter_rr_pkt_n #(
    .DWIDTH(DW),
    .N(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(inValid),
    .in_data(inData),
    .in_last(inLast),
    .in_ready(inReady),
    .out_valid(outValid),
    .out_data(outData),
    .out_last(outLast),
    .out_src(outSrc),
    .out_ready(outReady)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [N-1:0] v, input logic [N-1:0] l,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [DW-1:0] d2, input logic ordy,
                              input logic [N-1:0] er, input logic eov,
                              input logic p, input logic [DW-1:0] pd,
                              input logic pl, input logic [SW-1:0] ps);
    vec_t r;
    r.valid       = v;
    r.last        = l;
    r.data        = {d2, d1, d0};
    r.outReady    = ordy;
    r.expReady    = er;
    r.expOutValid = eov;
    r.push        = p;
    r.pData       = pd;
    r.pLast       = pl;
    r.pSrc        = ps;
    return r;
  endfunction

  function automatic logic [N-1:0] readyVec();
    return {inReady[2], inReady[1], inReady[0]};
  endfunction

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then let the scoreboard
  // consume a beat if the output transfers on the coming rising edge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l,
                               input logic [N-1:0][DW-1:0] d, input logic ordy);
    beat_t b;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      inValid[i] = v[i];
      inLast[i]  = l[i];
      inData[i]  = d[i];
    end
    outReady = ordy;
    #1;
    if (outValid && outReady) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_underflow: got beat src %0d data 0x%0h, required none",
                 outSrc, outData);
      end else begin
        b = sbQ.pop_front();
        checkOutput("beat_data", 32'(outData), 32'(b.data));
        checkOutput("beat_last", 32'(outLast), 32'(b.last));
        checkOutput("beat_src", 32'(outSrc), 32'(b.src));
      end
    end
  endtask

  task automatic runVectors(input int lo, input int hi);
    beat_t b;
    for (int i = lo; i < hi; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].outReady);
      checkOutput($sformatf("v%0d_in_ready", i), 32'(readyVec()), 32'(vecs[i].expReady));
      checkOutput($sformatf("v%0d_out_valid", i), 32'(outValid), 32'(vecs[i].expOutValid));
      if (vecs[i].push) begin
        b.data = vecs[i].pData;
        b.last = vecs[i].pLast;
        b.src  = vecs[i].pSrc;
        sbQ.push_back(b);
      end
    end
  endtask

  initial begin
    int segRr, segLock, segBubble, segBpPre, segBpPost, segLock2, segPost;

    // Round robin, single-beat packets from all three requesters.
    vecs.push_back(mk(3'b111, 3'b111, 'h100, 'h101, 'h102, 1, 3'b001, 0, 1, 'h100, 1, 0));
    vecs.push_back(mk(3'b111, 3'b111, 'h100, 'h101, 'h102, 1, 3'b010, 1, 1, 'h101, 1, 1));
    vecs.push_back(mk(3'b111, 3'b111, 'h100, 'h101, 'h102, 1, 3'b100, 1, 1, 'h102, 1, 2));
    vecs.push_back(mk(3'b111, 3'b111, 'h100, 'h101, 'h102, 1, 3'b001, 1, 1, 'h100, 1, 0));
    vecs.push_back(mk(3'b111, 3'b111, 'h100, 'h101, 'h102, 1, 3'b010, 1, 1, 'h101, 1, 1));
    vecs.push_back(mk(3'b111, 3'b111, 'h100, 'h101, 'h102, 1, 3'b100, 1, 1, 'h102, 1, 2));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0));
    segRr = vecs.size();
    // Packet lock: req0 3-beat packet while req1 waits with one beat.
    vecs.push_back(mk(3'b011, 3'b010, 'h0A0, 'h1B1, 0, 1, 3'b001, 0, 1, 'h0A0, 0, 0));
    vecs.push_back(mk(3'b011, 3'b010, 'h0A1, 'h1B1, 0, 1, 3'b001, 1, 1, 'h0A1, 0, 0));
    vecs.push_back(mk(3'b011, 3'b011, 'h0A2, 'h1B1, 0, 1, 3'b001, 1, 1, 'h0A2, 1, 0));
    vecs.push_back(mk(3'b010, 3'b010, 0, 'h1B1, 0, 1, 3'b010, 1, 1, 'h1B1, 1, 1));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0));
    segLock = vecs.size();
    // Owner bubble: ptr is now 2 but only req0/req1 are valid, so req0 wins.
    vecs.push_back(mk(3'b011, 3'b010, 'h0C0, 'h1C1, 0, 1, 3'b001, 0, 1, 'h0C0, 0, 0));
    vecs.push_back(mk(3'b010, 3'b010, 0, 'h1C1, 0, 1, 3'b001, 1, 0, 0, 0, 0));
    vecs.push_back(mk(3'b010, 3'b010, 0, 'h1C1, 0, 1, 3'b001, 0, 0, 0, 0, 0));
    vecs.push_back(mk(3'b011, 3'b010, 'h0C1, 'h1C1, 0, 1, 3'b001, 0, 1, 'h0C1, 0, 0));
    vecs.push_back(mk(3'b011, 3'b011, 'h0C2, 'h1C1, 0, 1, 3'b001, 1, 1, 'h0C2, 1, 0));
    vecs.push_back(mk(3'b010, 3'b010, 0, 'h1C1, 0, 1, 3'b010, 1, 1, 'h1C1, 1, 1));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0));
    segBubble = vecs.size();
    // Backpressure: ptr is 2, req2 sends a beat which is then stalled.
    vecs.push_back(mk(3'b100, 3'b100, 0, 0, 'h2D0, 1, 3'b100, 0, 1, 'h2D0, 1, 2));
    segBpPre = vecs.size();
    vecs.push_back(mk(3'b100, 3'b100, 0, 0, 'h2D1, 1, 3'b100, 1, 1, 'h2D1, 1, 2));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0));
    segBpPost = vecs.size();
    // Lock onto requester 2 with a multi-beat packet.
    vecs.push_back(mk(3'b100, 3'b000, 0, 0, 'h3E0, 1, 3'b100, 0, 1, 'h3E0, 0, 2));
    segLock2 = vecs.size();
    // After reset: ptr=0, so req0 goes before req2.
    vecs.push_back(mk(3'b101, 3'b101, 'h3F0, 0, 'h3E2, 1, 3'b001, 0, 1, 'h3F0, 1, 0));
    vecs.push_back(mk(3'b101, 3'b101, 'h3F0, 0, 'h3E2, 1, 3'b100, 1, 1, 'h3E2, 1, 2));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0));
    segPost = vecs.size();

    // Reset with every requester valid: nothing may be granted.
    rst      = 1'b1;
    outReady = 1'b1;
    for (int i = 0; i < N; i++) begin
      inValid[i] = 1'b1;
      inLast[i]  = 1'b1;
      inData[i]  = DW'(32'h555 + i);
    end
    @(negedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(readyVec()), 32'd0);
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_out_src", 32'(outSrc), 32'd0);
    checkOutput("reset_out_data", 32'(outData), 32'd0);
    for (int i = 0; i < N; i++) begin
      inValid[i] = 1'b0;
    end
    rst = 1'b0;

    runVectors(0, segRr);
    runVectors(segRr, segLock);
    runVectors(segLock, segBubble);
    runVectors(segBubble, segBpPre);

    // Stall the consumer for 4 cycles with a beat waiting at the output.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(3'b100, 3'b100, {20'h2D1, 20'h0, 20'h0}, 1'b0);
      checkOutput($sformatf("bp%0d_in_ready", c), 32'(readyVec()), 32'd0);
      checkOutput($sformatf("bp%0d_out_valid", c), 32'(outValid), 32'd1);
      checkOutput($sformatf("bp%0d_out_data", c), 32'(outData), 32'h2D0);
      checkOutput($sformatf("bp%0d_out_last", c), 32'(outLast), 32'd1);
      checkOutput($sformatf("bp%0d_out_src", c), 32'(outSrc), 32'd2);
    end
    runVectors(segBpPre, segBpPost);

    runVectors(segBpPost, segLock2);
    // Mid-packet on owner 2: req0 is valid but must not be served.
    @(negedge clk);
    inValid[0] = 1'b1;
    inValid[1] = 1'b0;
    inValid[2] = 1'b1;
    inLast[0]  = 1'b0;
    inLast[1]  = 1'b0;
    inLast[2]  = 1'b0;
    inData[0]  = 20'h3F0;
    inData[2]  = 20'h3E1;
    outReady   = 1'b1;
    #1;
    checkOutput("lock2_in_ready", 32'(readyVec()), 32'b100);
    checkOutput("lock2_out_valid", 32'(outValid), 32'd1);
    checkOutput("lock2_out_src", 32'(outSrc), 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
    checkOutput("midrst_out_src", 32'(outSrc), 32'd0);
    checkOutput("midrst_out_data", 32'(outData), 32'd0);
    checkOutput("midrst_in_ready", 32'(readyVec()), 32'd0);
    // The stalled beat from requester 2 is dropped by the reset.
    sbQ.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    runVectors(segLock2, segPost);

    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbiter_rr_pkt_n.md
Name: arbiter_rr_pkt_n

Overview:
- N-to-1 round-robin arbiter for valid/ready streams that carry packets delimited by a last flag.
- A grant is locked to one requester from its first accepted beat through its last beat, so packets are never interleaved.
- The output is registered: a one-entry pipeline stage that sustains full throughput.
- Sits in front of any shared single-port datapath consumer: NoC egress, memory request port, shared DMA channel.

Parameters:
- DWIDTH, 20, payload width in bits.
- N, 2, number of requesters; legal range is N >= 2.
- SWIDTH, $clog2(N), width of the source-index output. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1 x [N-1:0] (unpacked array)  per-requester valid.
- in_data  input  [DWIDTH-1:0] x [N-1:0] (unpacked array)  per-requester payload.
- in_last  input  1 x [N-1:0] (unpacked array)  per-requester final-beat flag.
- in_ready  output  1 x [N-1:0] (unpacked array)  per-requester ready.
- out_valid  output  1  registered output valid.
- out_data  output  DWIDTH  registered payload.
- out_last  output  1  registered last flag.
- out_src  output  SWIDTH  index of the requester that supplied the current output beat.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (async assert, applies immediately):
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - state=IDLE, owner=0, ptr=0. ptr is the highest-priority index.
  - All in_ready=0 while rst is high.
- Stage enable: load = ~out_valid | out_ready.
- State IDLE:
  - Select g = first i with in_valid[i]=1, scanning ptr, ptr+1, … mod N.
  - in_ready[g] = load. All other in_ready = 0. If no in_valid, all in_ready = 0.
  - On accept (in_valid[g] & in_ready[g]):
    - in_last[g]=1: stay IDLE, ptr <= (g+1) mod N.
    - in_last[g]=0: go to LOCKED, owner <= g.
- State LOCKED:
  - in_ready[owner] = load. All other in_ready = 0, regardless of their valid.
  - If the owner deasserts valid mid-packet, no other requester is served. The bubble is passed downstream as out_valid=0.
  - On accept with in_last[owner]=1: go to IDLE, ptr <= (owner+1) mod N.
- Output register:
  - On accept: out_valid<=1, out_data<=in_data[sel], out_last<=in_last[sel], out_src<=sel.
  - Else if out_ready: out_valid<=0. out_data, out_last and out_src hold their last values.
  - Else everything holds. out_data, out_last and out_src are stable whenever out_valid=1 & out_ready=0.
- Latency and throughput:
  - Latency from input accept to out_valid is 1 cycle.
  - Throughput is one beat per cycle when out_ready=1 continuously.
- in_ready may depend combinationally on in_valid and out_ready. There is no combinational path from in_data to any output.
- Fairness:
  - ptr advances only on packet completion.
  - With all requesters continuously valid, packets are granted in order ptr, ptr+1, … with no starvation.
- ptr wrap-around: owner or g equal to N-1 gives ptr=0.
- Simultaneous out_ready and accept in the same cycle: the new beat replaces the old one. No bubble and no duplication.
- Reset mid-packet: the packet in progress is abandoned and the output beat is dropped. The requester must restart the packet after reset.

Test Plan:
- Reset: hold rst=1 with all in_valid=1 -> in_ready all 0, out_valid=0, out_src=0. Deassert rst -> first output beat comes from requester 0.
- Round-robin, N=3, DWIDTH=20: all requesters send single-beat packets continuously (data 0x100+i), out_ready=1 -> out_src sequence 0,1,2,0,1,2. One beat per cycle. Data matches source.
- Packet lock: req0 sends a 3-beat packet (0xA0,0xA1,0xA2, last on beat 3) while req1 holds a 1-beat packet valid -> output 0xA0,0xA1,0xA2, then req1's beat. in_ready[1]=0 for the first 3 accept cycles.
- Owner bubble: req0 drops valid for 2 cycles after beat 1 of 3, req1 valid throughout -> out_valid=0 for 2 cycles, no req1 beat until req0's last beat completes.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out_data/out_last/out_src stable and all in_ready=0. Then out_ready=1 -> next beat the following cycle with no loss.
- Reset mid-operation: assert rst during LOCKED on owner 2 -> out_valid=0 immediately. After release, ptr=0, so req0 is granted first when req0 and req2 are both valid.
